// File: rtl/cache_mem_pkg.sv
// ---------------------------------------------------------------------------
// cache_mem_pkg
// Shared definitions for the memory side of the cache controller: line and
// word geometry, the responder state encoding, and the pattern a line holds
// before it has ever been written.
// ---------------------------------------------------------------------------
package cache_mem_pkg;

   localparam int LINE_BITS      = 512;
   localparam int WORD_BITS      = 32;
   localparam int WORDS_PER_LINE = 16;
   localparam int OFFSET_BITS    = 6;
   localparam int LINE_NO_BITS   = 32 - OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      WAIT_RELEASE
   } mem_state_t;

   // Contents of a never-written line. Each word carries the full line number
   // above its own 4-bit word index, zero-extended to 32 bits, so a fill that
   // lands in the wrong place or with words swapped is easy to spot.
   function automatic logic [LINE_BITS-1:0] default_line(input logic [LINE_NO_BITS-1:0] line_no);
      logic [LINE_BITS-1:0] line;
      line = '0;
      for (int j = 0; j < WORDS_PER_LINE; j++) begin
         line[j*WORD_BITS +: WORD_BITS] = {2'b00, line_no, 4'(j)};
      end
      return line;
   endfunction

endpackage

// File: rtl/line_store.sv
// ---------------------------------------------------------------------------
// line_store
// Backing array of 2^LINES_LOG2 lines of 512 bits with a per-line valid bit.
// Reads and writes are serialized by the owner, so a single line number
// serves both ports.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears valid + rd_data)
//   line_no    full line number (address[31:6]); low bits index the array,
//              all bits feed the default pattern
//   wr_en      commit wr_data to the indexed line and mark it valid
//   wr_data    512-bit line to store
//   rd_en      load rd_data from the indexed line (or its default pattern)
//   rd_data    registered read result, held until the next rd_en
// ---------------------------------------------------------------------------
module line_store
   import cache_mem_pkg::*;
#(
   parameter int LINES_LOG2 = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LINE_NO_BITS-1:0] line_no,
   input  logic                    wr_en,
   input  logic [LINE_BITS-1:0]    wr_data,
   input  logic                    rd_en,
   output logic [LINE_BITS-1:0]    rd_data
);

   localparam int LINES = 2 ** LINES_LOG2;

   logic [LINE_BITS-1:0]  mem [LINES];
   logic [LINES-1:0]      valid;
   logic [LINES_LOG2-1:0] idx;

   // Upper line-number bits alias onto the same entry.
   assign idx = line_no[LINES_LOG2-1:0];

   // NOTE: the data array has no reset; clearing the valid vector is what
   // makes every line read back as its default pattern after rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid   <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            valid[idx] <= 1'b1;
         end
         if (rd_en) begin
            rd_data <= valid[idx] ? mem[idx] : default_line(line_no);
         end
      end
   end

endmodule

// File: rtl/main_memory_responder.sv
// ---------------------------------------------------------------------------
// main_memory_responder
// Behavioural backing store for the cache miss path. Accepts one line read
// or write-back at a time, waits a fixed latency, then completes with a
// single-cycle mem_ready and waits for the request lines to drop.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_read        line read request (level, held until mem_ready)
//   mem_write       line write-back request (level, held until mem_ready)
//   mem_address     byte address, [5:0] ignored
//   mem_write_data  write-back line, word j at [j*32 +: 32]
//   mem_read_data   fill line, valid with mem_ready, held until next read
//   mem_ready       one-cycle completion pulse
//   proto_err       one-cycle pulse when read and write are accepted together
//   read_count      completed reads (wrapping)
//   write_count     completed writes (wrapping)
// ---------------------------------------------------------------------------
module main_memory_responder
   import cache_mem_pkg::*;
#(
   parameter int LINES_LOG2    = 10,
   parameter int READ_LATENCY  = 8,
   parameter int WRITE_LATENCY = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [31:0]          mem_address,
   input  logic [LINE_BITS-1:0] mem_write_data,
   output logic [LINE_BITS-1:0] mem_read_data,
   output logic                 mem_ready,
   output logic                 proto_err,
   output logic [31:0]          read_count,
   output logic [31:0]          write_count
);

   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   mem_state_t state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic accept, complete;

   // Transaction captured at accept; the request pins are ignored afterwards.
   logic [LINE_NO_BITS-1:0] cap_line_no;
   logic [LINE_BITS-1:0]    cap_data;
   logic                    cap_write;

   logic store_wr_en, store_rd_en;

   // Byte offset within a line never matters to a line-granular store.
   logic unused_offset;
   assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read || mem_write) begin
               accept     = 1'b1;
               state_next = BUSY;
               // Write wins when both are raised.
               cnt_next   = mem_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               complete   = 1'b1;
               state_next = WAIT_RELEASE;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         WAIT_RELEASE: begin
            // A request still held after mem_ready must not start a new access.
            if (!mem_read && !mem_write) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cap_line_no <= mem_address[31:OFFSET_BITS];
         cap_data    <= mem_write_data;
         cap_write   <= mem_write;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_ready   <= 1'b0;
         proto_err   <= 1'b0;
         read_count  <= '0;
         write_count <= '0;
      end else begin
         mem_ready <= complete;
         proto_err <= accept && mem_read && mem_write;
         if (complete && !cap_write) begin
            read_count <= read_count + 32'd1;
         end
         if (complete && cap_write) begin
            write_count <= write_count + 32'd1;
         end
      end
   end

   // Reset aborts an in-flight access: the array must not see its commit.
   assign store_wr_en = complete && cap_write && !rst;
   assign store_rd_en = complete && !cap_write && !rst;

   line_store #(
      .LINES_LOG2(LINES_LOG2)
   ) u_line_store (
      .clk    (clk),
      .rst    (rst),
      .line_no(cap_line_no),
      .wr_en  (store_wr_en),
      .wr_data(cap_data),
      .rd_en  (store_rd_en),
      .rd_data(mem_read_data)
   );

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

   localparam int RLAT = 8;
   localparam int WLAT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [511:0] mem_write_data;
   logic [511:0] mem_read_data;
   logic         mem_ready;
   logic         proto_err;
   logic [31:0]  read_count;
   logic [31:0]  write_count;

   main_memory_responder #(
      .LINES_LOG2   (10),
      .READ_LATENCY (RLAT),
      .WRITE_LATENCY(WLAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data),
      .mem_ready     (mem_ready),
      .proto_err     (proto_err),
      .read_count    (read_count),
      .write_count   (write_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic         is_read;
      logic [511:0] data;
      logic [31:0]  rc;
      logic [31:0]  wc;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_r = 0;
   logic [31:0] exp_w = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Line whose word j is base + j.
   function automatic logic [511:0] make_line(input logic [31:0] base);
      logic [511:0] l;
      for (int j = 0; j < 16; j++) l[j*32 +: 32] = base + 32'(j);
      return l;
   endfunction

   // Monitor: every mem_ready pulse must match the oldest expected completion.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && mem_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready: got pulse at cycle %0d want none", cyc);
         end else begin
            e = sb.pop_front();
            check("ready_cycle", 512'(cyc), 512'(e.cyc));
            if (e.is_read) check("read_data", mem_read_data, e.data);
            check("read_count", 512'(read_count), 512'(e.rc));
            check("write_count", 512'(write_count), 512'(e.wc));
         end
      end
   end

   // Issue one request, scramble the pins while busy, wait for mem_ready,
   // hold the request hold_extra more cycles, then release.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [511:0] wdata, input logic [511:0] exp_rdata,
                         input int hold_extra);
      exp_t e;
      bit seen;
      @(negedge clk);
      mem_read       = rd;
      mem_write      = wr;
      mem_address    = addr;
      mem_write_data = wdata;
      if (wr) exp_w++; else exp_r++;
      e.is_read = !wr;
      e.data    = exp_rdata;
      e.rc      = exp_r;
      e.wc      = exp_w;
      e.cyc     = cyc + 1 + (wr ? WLAT : RLAT);
      sb.push_back(e);
      @(negedge clk);
      check("proto_err", 512'(proto_err), 512'(rd && wr));
      mem_address    = ~addr;
      mem_write_data = ~wdata;
      seen = mem_ready;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = mem_ready;
      end
      check("ready_timeout", 512'(seen), 512'(1));
      repeat (hold_extra) @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst            = 1'b1;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ready", 512'(mem_ready), 512'(0));
      check("rst_proto_err", 512'(proto_err), 512'(0));
      check("rst_read_count", 512'(read_count), 512'(0));
      check("rst_write_count", 512'(write_count), 512'(0));
      check("rst_read_data", mem_read_data, 512'(0));

      // Never-written line: words 0x04000010..0x0400001F.
      do_req(1, 0, 32'h1000_0040, '0, make_line(32'h0400_0010), 0);
      // Write-back then read it back.
      do_req(0, 1, 32'h1000_0080, make_line(32'hA5A5_0000), '0, 0);
      do_req(1, 0, 32'h1000_0080, '0, make_line(32'hA5A5_0000), 0);
      // Aliasing: 0x00010000 maps to the same entry as 0x00000000.
      do_req(0, 1, 32'h0000_0000, make_line(32'h5A5A_0000), '0, 0);
      do_req(1, 0, 32'h0001_0000, '0, make_line(32'h5A5A_0000), 0);
      // Request held 3 cycles past mem_ready, then an immediate new read.
      do_req(1, 0, 32'h0000_0040, '0, make_line(32'h0000_0010), 3);
      do_req(1, 0, 32'h0000_0044, '0, make_line(32'h0000_0010), 0);
      // Read and write together: write wins, proto_err pulses.
      do_req(1, 1, 32'h0000_0100, make_line(32'h1234_0000), '0, 0);
      do_req(1, 0, 32'h0000_0100, '0, make_line(32'h1234_0000), 0);

      // Reset three cycles into a read: no completion, counters cleared.
      @(negedge clk);
      mem_read    = 1'b1;
      mem_address = 32'h1000_0040;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      mem_read = 1'b0;
      exp_r    = 0;
      exp_w    = 0;
      check("abort_read_count", 512'(read_count), 512'(0));
      check("abort_write_count", 512'(write_count), 512'(0));
      check("abort_read_data", mem_read_data, 512'(0));
      repeat (12) @(negedge clk);
      check("abort_no_ready", 512'(mem_ready), 512'(0));
      do_req(1, 0, 32'h1000_0040, '0, make_line(32'h0400_0010), 0);
      // Valid bits were cleared: the earlier write-back is gone.
      do_req(1, 0, 32'h1000_0080, '0, make_line(32'h0400_0020), 0);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 512'(sb.size()), 512'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
